// File: rtl/cmt_trace_fifo_if.sv
// Commit-trace bundle between the commit stage, the trace FIFO and its consumer.
//   Commit side : trace_en, cmt_valid0/1, cmt_inst0/1, cmt_excp0/1 (slot0 older)
//   Trace side  : trace_valid/trace_ready handshake, trace_inst/excp/seq head record
//   Status      : drop_cnt (saturating), overflow (sticky)
// slave modport is the FIFO; master modport is the surrounding environment.
interface cmt_trace_fifo_if #(
   parameter int unsigned SEQ_W  = 32,
   parameter int unsigned DROP_W = 16
);
   logic              trace_en;
   logic              cmt_valid0;
   logic [31:0]       cmt_inst0;
   logic [6:0]        cmt_excp0;
   logic              cmt_valid1;
   logic [31:0]       cmt_inst1;
   logic [6:0]        cmt_excp1;
   logic              trace_valid;
   logic              trace_ready;
   logic [31:0]       trace_inst;
   logic [6:0]        trace_excp;
   logic [SEQ_W-1:0]  trace_seq;
   logic [DROP_W-1:0] drop_cnt;
   logic              overflow;

   modport slave (
      input  trace_en, cmt_valid0, cmt_inst0, cmt_excp0,
      input  cmt_valid1, cmt_inst1, cmt_excp1, trace_ready,
      output trace_valid, trace_inst, trace_excp, trace_seq, drop_cnt, overflow
   );

   modport master (
      output trace_en, cmt_valid0, cmt_inst0, cmt_excp0,
      output cmt_valid1, cmt_inst1, cmt_excp1, trace_ready,
      input  trace_valid, trace_inst, trace_excp, trace_seq, drop_cnt, overflow
   );
endinterface

// File: rtl/cmt_trace_fifo.sv
// Commit-trace capture FIFO. Accepts up to two commits per cycle in program order,
// tags each with a sequence number, emits one record per cycle over valid/ready and
// counts commits lost to overflow.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : cmt_trace_fifo_if.slave (commit inputs, trace outputs, drop status)
module cmt_trace_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned SEQ_W  = 32,
   parameter int unsigned DROP_W = 16
) (
   input logic             clk,
   input logic             rst,
   cmt_trace_fifo_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = DROP_W + 1;

   logic [31:0]      inst_mem [DEPTH];
   logic [6:0]       excp_mem [DEPTH];
   logic [SEQ_W-1:0] seq_mem  [DEPTH];

   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]  count_q, count_d, free;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              ovf_q, ovf_d;

   logic              v0, v1, pop;
   logic [1:0]        n, k, drops;
   logic [31:0]       first_inst;
   logic [6:0]        first_excp;
   logic [SUM_W-1:0]  drop_sum;

   always_comb begin
      v0         = bus.trace_en & bus.cmt_valid0;
      v1         = bus.trace_en & bus.cmt_valid1;
      n          = {1'b0, v0} + {1'b0, v1};
      // Oldest valid commit goes first; a lone slot1 commit takes the first position.
      first_inst = v0 ? bus.cmt_inst0 : bus.cmt_inst1;
      first_excp = v0 ? bus.cmt_excp0 : bus.cmt_excp1;
      // Space is judged on the pre-pop occupancy: a same-cycle pop frees nothing.
      free       = CNT_W'(DEPTH) - count_q;
      k          = (free >= {{(CNT_W-2){1'b0}}, n}) ? n : free[1:0];
      drops      = n - k;
      pop        = (count_q != '0) && bus.trace_ready;
      count_d    = count_q + CNT_W'(k) - CNT_W'(pop);
      wr_d       = wr_q + PTR_W'(k);
      rd_d       = rd_q + PTR_W'(pop);
      // Dropped commits still consume sequence numbers so gaps mark the loss.
      seq_d      = seq_q + SEQ_W'(n);
      drop_sum   = {1'b0, drop_q} + SUM_W'(drops);
      drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      ovf_d      = ovf_q | (drops != 2'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         seq_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         seq_q   <= seq_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            inst_mem[i] <= '0;
            excp_mem[i] <= '0;
            seq_mem[i]  <= '0;
         end
      end else begin
         if (k != 2'd0) begin
            inst_mem[wr_q] <= first_inst;
            excp_mem[wr_q] <= first_excp;
            seq_mem[wr_q]  <= seq_q;
         end
         // k == 2 only when both slots are valid, so the second entry is always slot1.
         if (k == 2'd2) begin
            inst_mem[wr_q + PTR_W'(1)] <= bus.cmt_inst1;
            excp_mem[wr_q + PTR_W'(1)] <= bus.cmt_excp1;
            seq_mem[wr_q + PTR_W'(1)]  <= seq_q + SEQ_W'(1);
         end
      end
   end

   assign bus.trace_valid = (count_q != '0);
   assign bus.trace_inst  = inst_mem[rd_q];
   assign bus.trace_excp  = excp_mem[rd_q];
   assign bus.trace_seq   = seq_mem[rd_q];
   assign bus.drop_cnt    = drop_q;
   assign bus.overflow    = ovf_q;
endmodule
